// File: rtl/stack_ram_arbiter.sv
// Arbiter sharing the single-port stack RAM between the core and the host debug/loader port.
// Core has priority, bounded by a starvation counter; host_lock gives the host exclusive bursts.
//   state | meaning
//   ARB   | per-cycle arbitration: core first, host after STARVE_MAX core grants
//   LOCK  | host owns the RAM, core stalled and held pending
module stack_ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              core_clock,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              core_win, host_win;
  logic              rd_core_q, rd_host_q;
  logic              core_gnt_q, host_gnt_q, core_rvalid_q, host_rvalid_q;
  logic              core_stall_q, ram_wren_q;
  logic [DATA_W-1:0] core_rdata_q, host_rdata_q, ram_data_q;
  logic [ADDR_W-1:0] ram_addr_q;

  always_comb begin
    core_win = 1'b0;
    host_win = 1'b0;
    state_d  = (state_q == LOCK && !host_lock) ? ARB : state_q;
    if (state_q == LOCK && host_lock) begin
      host_win = host_req;
    end else if (host_req && host_lock) begin
      host_win = 1'b1;
      state_d  = LOCK;
    end else if (host_req && (!core_req || starve_q == STARVE_LIM)) begin
      host_win = 1'b1;
    end else if (core_req) begin
      core_win = 1'b1;
    end
  end

  // The counter only measures core grants that actually made a waiting host wait longer.
  always_comb begin
    starve_d = starve_q;
    if (host_win || !host_req)
      starve_d = '0;
    else if (core_win && starve_q != STARVE_LIM)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge core_clock or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB;
      starve_q      <= '0;
      rd_core_q     <= 1'b0;
      rd_host_q     <= 1'b0;
      core_gnt_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
      core_stall_q  <= 1'b0;
      ram_wren_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      core_gnt_q    <= core_win;
      host_gnt_q    <= host_win;
      core_stall_q  <= (state_d == LOCK);
      ram_wren_q    <= (core_win & core_we) | (host_win & host_we);
      rd_core_q     <= core_win & ~core_we;
      rd_host_q     <= host_win & ~host_we;
      core_rvalid_q <= rd_core_q;
      host_rvalid_q <= rd_host_q;
      if (core_win) begin
        ram_addr_q <= core_addr;
        ram_data_q <= core_wdata;
      end else if (host_win) begin
        ram_addr_q <= host_addr;
        ram_data_q <= host_wdata;
      end
      // RAM latched the granted address on the negedge, so ram_q is settled here.
      if (rd_core_q) core_rdata_q <= ram_q;
      if (rd_host_q) host_rdata_q <= ram_q;
    end
  end

  assign core_gnt    = core_gnt_q;
  assign host_gnt    = host_gnt_q;
  assign core_rvalid = core_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign host_rdata  = host_rdata_q;
  assign core_stall  = core_stall_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

endmodule

// File: tb/tb_stack_ram_arbiter.sv
// Scoreboard bench for stack_ram_arbiter: a transaction-level reference model predicts grants and
// read data, a negedge monitor compares every cycle and pops expected read data on rvalid.
module tb_stack_ram_arbiter;
  localparam int SMAX = 4;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       lock;
  } txn_t;

  logic       core_clock = 1'b0;
  logic       rst = 1'b0;
  logic       core_req = 1'b0, core_we = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0;
  logic       host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       core_gnt, core_rvalid, host_gnt, host_rvalid, core_stall, ram_wren;
  logic [7:0] core_rdata, host_rdata, ram_addr, ram_data;
  logic [7:0] ram_q = '0;
  logic [7:0] ram_mem [0:255];

  always #5 core_clock = ~core_clock;

  stack_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(SMAX)) dut (
    .core_clock(core_clock), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .core_stall(core_stall), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // Single-port RAM on the falling edge
  always @(negedge core_clock) begin
    if (ram_wren) ram_mem[ram_addr] = ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (transaction level)
  logic       m_lock = 0, m_cgnt = 0, m_hgnt = 0, m_wren = 0, m_stall = 0;
  logic       m_crv = 0, m_hrv = 0, m_cpend = 0, m_hpend = 0;
  logic [7:0] m_addr = '0, m_data = '0;
  int         m_wait = 0;
  logic [7:0] mdl_mem [0:255];
  logic [7:0] exp_core_q[$];
  logic [7:0] exp_host_q[$];
  txn_t       core_q[$];
  txn_t       host_q[$];
  txn_t       cur_c = '0, cur_h = '0;
  string      gseq = "";

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = 0; m_cgnt = 0; m_hgnt = 0; m_wren = 0; m_stall = 0;
    m_crv = 0; m_hrv = 0; m_cpend = 0; m_hpend = 0;
    m_addr = '0; m_data = '0; m_wait = 0;
    exp_core_q.delete();
    exp_host_q.delete();
  endtask

  // One sampling edge of the arbiter as seen from outside: who wins, what the RAM sees.
  task automatic model_edge();
    bit cw, hw;
    cw = 0; hw = 0;
    m_crv = m_cpend;
    m_hrv = m_hpend;
    if (m_lock && host_lock) begin
      hw = host_req;
    end else begin
      m_lock = 0;
      if (host_req && host_lock) begin hw = 1; m_lock = 1; end
      else if (host_req && (!core_req || m_wait >= SMAX)) hw = 1;
      else if (core_req) cw = 1;
    end
    if (hw || !host_req) m_wait = 0;
    else if (cw) m_wait = (m_wait + 1 > SMAX) ? SMAX : m_wait + 1;
    m_cgnt = cw; m_hgnt = hw; m_wren = 0; m_cpend = 0; m_hpend = 0;
    if (cw) begin
      gseq = {gseq, "C"};
      m_addr = core_addr; m_data = core_wdata;
      if (core_we) begin m_wren = 1; mdl_mem[core_addr] = core_wdata; end
      else begin m_cpend = 1; exp_core_q.push_back(mdl_mem[core_addr]); end
    end
    if (hw) begin
      gseq = {gseq, "H"};
      m_addr = host_addr; m_data = host_wdata;
      if (host_we) begin m_wren = 1; mdl_mem[host_addr] = host_wdata; end
      else begin m_hpend = 1; exp_host_q.push_back(mdl_mem[host_addr]); end
    end
    m_stall = m_lock;
  endtask

  task automatic drive();
    core_req = cur_c.req; core_we = cur_c.we; core_addr = cur_c.addr; core_wdata = cur_c.data;
    host_req = cur_h.req; host_we = cur_h.we; host_addr = cur_h.addr; host_wdata = cur_h.data;
    host_lock = cur_h.lock;
  endtask

  task automatic step();
    @(posedge core_clock);
    if (rst) model_edge();
    #1;
    if (m_cgnt || !cur_c.req) begin
      if (core_q.size() != 0) cur_c = core_q.pop_front(); else cur_c = '0;
    end
    if (m_hgnt || !cur_h.req) begin
      if (host_q.size() != 0) cur_h = host_q.pop_front(); else cur_h = '0;
    end
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((core_q.size() != 0 || host_q.size() != 0 || cur_c.req || cur_h.req ||
            m_cpend || m_hpend) && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL idle_timeout @%0t: still busy after %0d cycles", $time, n);
    end
    step();
    step();
  endtask

  function automatic txn_t mk(input logic we, input logic [7:0] addr, input logic [7:0] data,
                              input logic lock);
    txn_t t;
    t.req = 1'b1; t.we = we; t.addr = addr; t.data = data; t.lock = lock;
    return t;
  endfunction

  // Monitor: compares every cycle and pops read data when the DUT presents rvalid.
  initial forever begin
    @(negedge core_clock);
    chk1("core_gnt", core_gnt, m_cgnt);
    chk1("host_gnt", host_gnt, m_hgnt);
    chk1("ram_wren", ram_wren, m_wren);
    chk1("core_stall", core_stall, m_stall);
    chk8("ram_addr", ram_addr, m_addr);
    chk8("ram_data", ram_data, m_data);
    chk1("core_rvalid", core_rvalid, m_crv);
    chk1("host_rvalid", host_rvalid, m_hrv);
    if (core_rvalid) begin
      if (exp_core_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL core_rdata @%0t: got %02h with no read outstanding", $time, core_rdata);
      end else chk8("core_rdata", core_rdata, exp_core_q.pop_front());
    end
    if (host_rvalid) begin
      if (exp_host_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL host_rdata @%0t: got %02h with no read outstanding", $time, host_rdata);
      end else chk8("host_rdata", host_rdata, exp_host_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 8'(i * 7 + 3);
      mdl_mem[i] = 8'(i * 7 + 3);
    end
    model_reset();

    // Reset held with both requesters active: nothing may be granted or written.
    core_q.push_back(mk(1'b1, 8'h20, 8'h11, 1'b0));
    host_q.push_back(mk(1'b1, 8'h21, 8'h22, 1'b0));
    repeat (4) step();
    rst = 1'b1;
    gseq = "";
    run_until_idle(20);
    chk8("reset_first_grant", gseq.len() > 0 ? 8'(gseq[0]) : 8'h00, 8'h43);

    // Core write then read of the same address
    core_q.push_back(mk(1'b1, 8'h05, 8'hA7, 1'b0));
    core_q.push_back(mk(1'b0, 8'h05, 8'h00, 1'b0));
    run_until_idle(20);

    // Contention: both held high
    for (int i = 0; i < 8; i++) core_q.push_back(mk(1'b0, 8'(i), 8'h00, 1'b0));
    host_q.push_back(mk(1'b0, 8'h40, 8'h00, 1'b0));
    host_q.push_back(mk(1'b0, 8'h41, 8'h00, 1'b0));
    gseq = "";
    run_until_idle(40);
    n_cmp++;
    if (gseq != "CCCCHCCCCH") begin
      n_bad++;
      $display("FAIL contention_seq: got %s expected CCCCHCCCCH", gseq);
    end

    // Locked host burst while the core waits
    core_q.push_back(mk(1'b0, 8'h12, 8'h00, 1'b0));
    for (int i = 0; i < 4; i++) host_q.push_back(mk(1'b1, 8'(8'h10 + i), 8'(i + 1), 1'b1));
    gseq = "";
    run_until_idle(40);
    n_cmp++;
    if (gseq != "HHHHC") begin
      n_bad++;
      $display("FAIL lock_seq: got %s expected HHHHC", gseq);
    end

    // Reset between a host read grant and its rvalid
    host_q.push_back(mk(1'b0, 8'h13, 8'h00, 1'b0));
    n = 0;
    step();
    while (!m_hgnt && n < 20) begin step(); n++; end
    chk1("mid_read_grant_seen", m_hgnt, 1'b1);
    rst = 1'b0;
    model_reset();
    cur_c = '0; cur_h = '0;
    drive();
    repeat (3) step();
    rst = 1'b1;
    core_q.push_back(mk(1'b0, 8'h13, 8'h00, 1'b0));
    run_until_idle(20);

    // Top address: host write, then back-to-back core reads
    host_q.push_back(mk(1'b1, 8'hFF, 8'h3C, 1'b0));
    run_until_idle(20);
    repeat (3) core_q.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b0));
    run_until_idle(20);

    // Randomised traffic over a small address window to stress ordering
    for (int c = 0; c < 400; c++) begin
      txn_t t;
      if (core_q.size() < 2) begin
        t = mk(1'($urandom_range(1)), 8'($urandom_range(7)), 8'($urandom), 1'b0);
        t.req = ($urandom_range(3) != 0);
        core_q.push_back(t);
      end
      if (host_q.size() < 2) begin
        t = mk(1'($urandom_range(1)), ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom_range(7)),
               8'($urandom), 1'($urandom_range(3) == 0));
        t.req = ($urandom_range(1) != 0);
        host_q.push_back(t);
      end
      step();
    end
    run_until_idle(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
